// File: rtl/io_core_port_if.sv
// Core-side bundle of the UART IO port: CPU byte requests on one side,
// IO-block strobes and BRAM lanes on the other.
interface io_core_port_if;
    logic        rd_req;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        wr_req;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic [31:0] indoutb;
    logic        corereadok;
    logic        coreread;
    logic [31:0] outdina;
    logic [3:0]  outwea;
    logic [1:0]  corewritewhere;
    logic        corewriteok;
    logic        corewrite;

    modport master (
        output rd_req, wr_req, wr_data, indoutb, corereadok, corewritewhere, corewriteok,
        input  rd_data, rd_valid, wr_ack, coreread, outdina, outwea, corewrite
    );

    modport slave (
        input  rd_req, wr_req, wr_data, indoutb, corereadok, corewritewhere, corewriteok,
        output rd_data, rd_valid, wr_ack, coreread, outdina, outwea, corewrite
    );
endinterface

// File: rtl/io_core_port.sv
// Core endpoint of the UART IO block: byte reads from the input BRAM word and
// byte-lane writes into the output BRAM, each confirmed by a one-cycle strobe.
//
// state    | meaning
// R_IDLE   | may consume a byte once the settle counter has reached 0
// R_SETTLE | waiting for IO pointer update and BRAM read latency
// W_IDLE   | may accept a write when the output buffer has room
// W_HOLD   | write outputs quiet for one cycle while corewriteok updates
module io_core_port #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    io_core_port_if.slave  bus
);
    localparam logic [2:0] SETTLE_INIT = 3'(SETTLE_CYCLES);

    typedef enum logic {R_IDLE, R_SETTLE} rd_state_t;
    typedef enum logic {W_IDLE, W_HOLD}   wr_state_t;

    rd_state_t   rd_state, rd_state_n;
    logic [2:0]  settle_cnt, settle_cnt_n;
    logic [1:0]  rd_lane, rd_lane_n;
    logic [7:0]  rd_data_q, rd_data_n;
    logic        rd_pulse_q, rd_pulse_n;

    wr_state_t   wr_state, wr_state_n;
    logic [31:0] outdina_q, outdina_n;
    logic [3:0]  outwea_q, outwea_n;
    logic        wr_pulse_q, wr_pulse_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_state   <= R_IDLE;
            settle_cnt <= SETTLE_INIT;
            rd_lane    <= 2'd0;
            rd_data_q  <= 8'd0;
            rd_pulse_q <= 1'b0;
            wr_state   <= W_IDLE;
            outdina_q  <= 32'd0;
            outwea_q   <= 4'd0;
            wr_pulse_q <= 1'b0;
        end else begin
            rd_state   <= rd_state_n;
            settle_cnt <= settle_cnt_n;
            rd_lane    <= rd_lane_n;
            rd_data_q  <= rd_data_n;
            rd_pulse_q <= rd_pulse_n;
            wr_state   <= wr_state_n;
            outdina_q  <= outdina_n;
            outwea_q   <= outwea_n;
            wr_pulse_q <= wr_pulse_n;
        end
    end

    // The counter also runs in R_IDLE so the first read after reset waits out a settle window.
    always_comb begin
        rd_state_n   = rd_state;
        settle_cnt_n = settle_cnt;
        rd_lane_n    = rd_lane;
        rd_data_n    = rd_data_q;
        rd_pulse_n   = 1'b0;
        case (rd_state)
            R_SETTLE: begin
                settle_cnt_n = (settle_cnt != 3'd0) ? settle_cnt - 3'd1 : 3'd0;
                if (settle_cnt_n == 3'd0) rd_state_n = R_IDLE;
            end
            R_IDLE: begin
                if (settle_cnt != 3'd0) begin
                    settle_cnt_n = settle_cnt - 3'd1;
                end else if (bus.rd_req && bus.corereadok) begin
                    rd_data_n    = bus.indoutb[{rd_lane, 3'b000} +: 8];
                    rd_pulse_n   = 1'b1;
                    rd_lane_n    = rd_lane + 2'd1;
                    settle_cnt_n = SETTLE_INIT;
                    rd_state_n   = R_SETTLE;
                end
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    // Enables, data and strobe are registered together so the BRAM write uses the pre-increment address.
    always_comb begin
        wr_state_n = wr_state;
        outdina_n  = 32'd0;
        outwea_n   = 4'd0;
        wr_pulse_n = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (bus.wr_req && bus.corewriteok) begin
                    outdina_n  = {4{bus.wr_data}};
                    outwea_n   = 4'b0001 << bus.corewritewhere;
                    wr_pulse_n = 1'b1;
                    wr_state_n = W_HOLD;
                end
            end
            W_HOLD:  wr_state_n = W_IDLE;
            default: wr_state_n = W_IDLE;
        endcase
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_pulse_q;
    assign bus.coreread  = rd_pulse_q;
    assign bus.outdina   = outdina_q;
    assign bus.outwea    = outwea_q;
    assign bus.corewrite = wr_pulse_q;
    assign bus.wr_ack    = wr_pulse_q;
endmodule

// File: tb/tb_io_core_port.sv
// Directed bench for io_core_port with a cycle-level behavioural model checked every cycle.
module tb_io_core_port;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    io_core_port_if bus ();

    io_core_port #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: edges remaining before a read may be accepted, byte lane, write busy flag.
    logic       m_on = 1'b0;
    int         rd_block = 0;
    int         m_lane = 0;
    logic       e_rd_valid = 1'b0;
    logic [7:0] e_rd_data = 8'd0;
    logic       e_wr = 1'b0;
    logic [7:0] e_data = 8'd0;
    logic [1:0] e_where = 2'd0;
    logic       w_busy = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_on       = 1'b1;
            rd_block   = SETTLE;
            m_lane     = 0;
            e_rd_valid = 1'b0;
            e_wr       = 1'b0;
            w_busy     = 1'b0;
        end else begin
            e_rd_valid = 1'b0;
            if (rd_block > 0) begin
                rd_block--;
            end else if (bus.rd_req && bus.corereadok) begin
                e_rd_valid = 1'b1;
                e_rd_data  = 8'(bus.indoutb >> (8 * m_lane));
                m_lane     = (m_lane + 1) % 4;
                rd_block   = SETTLE;
            end
            e_wr = 1'b0;
            if (w_busy) begin
                w_busy = 1'b0;
            end else if (bus.wr_req && bus.corewriteok) begin
                e_wr    = 1'b1;
                e_data  = bus.wr_data;
                e_where = bus.corewritewhere;
                w_busy  = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("m_rd_valid", bus.rd_valid, e_rd_valid);
            chk("m_coreread", bus.coreread, e_rd_valid);
            if (e_rd_valid) chk("m_rd_data", bus.rd_data, e_rd_data);
            chk("m_corewrite", bus.corewrite, e_wr);
            chk("m_wr_ack", bus.wr_ack, e_wr);
            chk("m_outwea", bus.outwea, e_wr ? (32'd1 << e_where) : 32'd0);
            chk("m_outdina", bus.outdina, e_wr ? {e_data, e_data, e_data, e_data} : 32'd0);
        end
    end

    task automatic wait_rd(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.rd_valid) begin
                n = i;
                break;
            end
        end
    endtask

    logic [7:0] exp_b [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    initial begin
        int n, hit, pulses, first, last;
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        bus.wr_data = 8'd0;
        bus.indoutb = 32'h44332211;
        bus.corereadok = 1'b0;
        bus.corewritewhere = 2'd0;
        bus.corewriteok = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {bus.rd_valid, bus.coreread, bus.wr_ack, bus.corewrite, bus.outwea}, 32'd0);
        chk("rst_outdina", bus.outdina, 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'd0);

        // Release reset with a read already pending: blocked for the settle window.
        rst = 1'b1;
        bus.rd_req = 1'b1;
        bus.corereadok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rd(10, n);
            chk("rd_gap", n, 3);
            chk("rd_byte", bus.rd_data, exp_b[i]);
            chk("rd_coreread", bus.coreread, 1);
        end

        bus.corereadok = 1'b0;
        hit = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rd_valid || bus.coreread) hit++;
        end
        chk("rd_blocked", hit, 0);
        bus.corereadok = 1'b1;
        wait_rd(10, n);
        chk("rd_resume_gap", n, 1);
        chk("rd_resume_byte", bus.rd_data, 8'h22);
        bus.rd_req = 1'b0;
        bus.corereadok = 1'b0;

        bus.wr_req = 1'b1;
        bus.wr_data = 8'hA5;
        bus.corewritewhere = 2'd2;
        bus.corewriteok = 1'b1;
        @(negedge clk);
        chk("wr_outwea", bus.outwea, 4'b0100);
        chk("wr_outdina", bus.outdina, 32'hA5A5A5A5);
        chk("wr_corewrite", bus.corewrite, 1);
        chk("wr_ack", bus.wr_ack, 1);
        bus.wr_req = 1'b0;
        @(negedge clk);
        chk("wr_hold_wea", bus.outwea, 0);

        bus.corewriteok = 1'b0;
        bus.wr_req = 1'b1;
        bus.wr_data = 8'h3C;
        bus.corewritewhere = 2'd1;
        hit = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.corewrite || bus.outwea != 4'd0) hit++;
        end
        chk("wr_stall", hit, 0);
        bus.corewriteok = 1'b1;
        pulses = 0;
        first = 0;
        last = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.corewrite) begin
                pulses++;
                if (pulses == 1) first = i;
                else chk("wr_gap", i - last, 2);
                last = i;
            end
        end
        chk("wr_pulses", pulses, 4);
        chk("wr_first", first, 1);
        bus.wr_req = 1'b0;
        bus.corewriteok = 1'b0;
        repeat (2) @(negedge clk);

        // Simultaneous read and write, then reset while the read path is settling.
        bus.rd_req = 1'b1;
        bus.corereadok = 1'b1;
        bus.wr_req = 1'b1;
        bus.corewriteok = 1'b1;
        bus.wr_data = 8'h5A;
        bus.corewritewhere = 2'd3;
        @(negedge clk);
        chk("both_coreread", bus.coreread, 1);
        chk("both_corewrite", bus.corewrite, 1);
        chk("both_rd_byte", bus.rd_data, 8'h33);
        chk("both_outwea", bus.outwea, 4'b1000);
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_strobes", {bus.rd_valid, bus.coreread, bus.wr_ack, bus.corewrite, bus.outwea}, 32'd0);
        rst = 1'b1;
        bus.rd_req = 1'b1;
        wait_rd(10, n);
        chk("post_rst_gap", n, 3);
        chk("post_rst_lane0", bus.rd_data, 8'h11);
        bus.rd_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
